instruction_memory: RTL and testbench
=====================================

Name: instruction_memory

Overview:
Responder end of the instruction-fetch interface: accepts imem_req/imem_addr from the fetch stage and returns an ILEN-bit instruction with a one-cycle imem_ack pulse after a configurable number of wait states. Storage is a halfword array. A program-load write port initialises it from the bench or a boot loader. Sits beside the core as the instruction-side memory model or on-chip ROM/RAM.

Parameters:
MEM_DEPTH, 1024, number of 16-bit halfwords stored
LATENCY, 1, wait states between request acceptance and response (0..15)

Ports:
clk_i  in  1  global clock
rst_i  in  1  synchronous active-high reset
imem_req_i  in  1  fetch request
imem_addr_i  in  ADDR_WIDTH  byte address of instruction; bit 0 ignored
imem_rdata_o  out  ILEN  instruction data, valid while imem_ack_o=1
imem_ack_o  out  1  response strobe, one cycle per accepted request
prog_we_i  in  1  program-load write enable
prog_addr_i  in  ADDR_WIDTH  byte address of halfword to write; bit 0 ignored
prog_wdata_i  in  HWORD_WIDTH  halfword write data

Behaviour:
- One clock; reset is synchronous and active-high (clk_i, rst_i).
- Reset values:
  - state=IDLE, wait counter=0, latched address=0, imem_ack_o=0, imem_rdata_o=0.
  - Memory contents are not reset.
- States: IDLE, WAIT, RESP.
- Ready = state IDLE or RESP. A request is accepted on an edge where ready and imem_req_i=1; imem_addr_i is latched on that edge.
- On acceptance:
  - LATENCY=0: next state RESP.
  - Otherwise: next state WAIT, counter=LATENCY-1.
- WAIT: counter decrements each cycle. When the counter is 0, next state is RESP. Requests are ignored in WAIT, with no acceptance and no queueing.
- RESP: imem_ack_o=1 for exactly this cycle.
  - With imem_req_i=1, a new request is accepted (transition per acceptance rules).
  - Otherwise, next state is IDLE.
- Latency: ack is high L+1 cycles after the acceptance edge. LATENCY=0 sustains one response per cycle with a continuous request. LATENCY=L>0 gives one response per L+1 cycles.
- imem_rdata_o is registered on the edge entering RESP and holds its value until the next RESP entry. It is not cleared when ack drops.
- Read assembly:
  - idx = latched_addr[..:1].
  - Halfword k of the instruction (k=0..ILEN/16-1) = mem[idx+k], placed at bits [16k+15:16k], little-endian.
  - Any idx+k >= MEM_DEPTH reads as 0. There is no wrap-around.
- Write: prog_we_i=1 writes mem[prog_addr_i[..:1]] on the edge. Out-of-range writes are dropped.
- Writes are independent of FSM state. A write on the same edge as read capture is not visible in that read (read-before-write).
- Reset mid-transaction: the pending request is discarded, no ack is issued, and state returns to IDLE next cycle. A write on the reset edge is still performed.
- ILEN must be a multiple of 16. LATENCY>15 or ILEN%16!=0 prints a SIMULATION-only initial error.

Decomposition:
- sp_pkg gains HWORD_WIDTH=16 and typedef enum imem_state_e {IMEM_IDLE, IMEM_WAIT, IMEM_RESP}. ADDR_WIDTH and ILEN come from sp_pkg.
- One sub-module, imem_storage: halfword array, synchronous write port, and combinational multi-halfword read with the out-of-range-zero rule.
- FSM, counter and output registers live in instruction_memory.

Test Plan:
- Reset: hold rst_i 3 cycles with imem_req_i=1 -> imem_ack_o=0 and imem_rdata_o=0 throughout; first ack 2 cycles after release (LATENCY=1).
- Load mem[8]=0x1234, mem[9]=0xABCD; LATENCY=1; request addr 0x10 -> ack exactly 2 cycles after acceptance with rdata=0xABCD1234 (ILEN=32). Ack is a single-cycle pulse.
- LATENCY=0, req held high, addresses 0x0, 0x2, 0x4 on consecutive cycles -> ack high 3 consecutive cycles with rdata {mem[1],mem[0]}, {mem[2],mem[1]}, {mem[3],mem[2]}.
- LATENCY=3, addr changes during WAIT -> response uses the originally latched address; the next acceptance occurs only in the RESP cycle; ack spacing is 4 cycles.
- Boundary: MEM_DEPTH=1024, addr 0x7FE -> rdata={16'h0, mem[1023]}; addr 0x800 -> rdata=0; prog write to 0x800 -> no memory change.
- Reset asserted in WAIT (LATENCY=3), then prog write of mem[0]=0xBEEF coincident with read capture of addr 0 -> no ack for the aborted request; captured data is the old mem[0]; the following read returns 0xBEEF.

Source files
------------

// File: rtl/sp_pkg.sv
// Shared core definitions for the instruction-side memory.
// Widths and the responder FSM state encoding.
package sp_pkg;

    localparam int ADDR_WIDTH  = 32;
    localparam int ILEN        = 32;
    localparam int HWORD_WIDTH = 16;

    typedef enum logic [1:0] {
        IMEM_IDLE,
        IMEM_WAIT,
        IMEM_RESP
    } imem_state_e;

endpackage

// File: rtl/imem_storage.sv
// Halfword array with a synchronous program-load write port and a
// combinational little-endian multi-halfword read; reads past the end give 0.
module imem_storage
    import sp_pkg::*;
#(
    parameter int MEM_DEPTH = 1024
) (
    input  logic                   i_clk,
    input  logic                   i_we,
    input  logic [ADDR_WIDTH-1:0]  i_waddr,
    input  logic [HWORD_WIDTH-1:0] i_wdata,
    input  logic [ADDR_WIDTH-1:0]  i_raddr,
    output logic [ILEN-1:0]        o_rdata
);

    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int NHW   = ILEN / HWORD_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] DEPTH = ADDR_WIDTH'(MEM_DEPTH);

    logic [HWORD_WIDTH-1:0] r_mem [MEM_DEPTH];
    logic [ADDR_WIDTH-1:0]  w_widx;
    logic [ADDR_WIDTH-1:0]  w_ridx;
    logic                   w_unused;

    assign w_widx   = {1'b0, i_waddr[ADDR_WIDTH-1:1]};
    assign w_ridx   = {1'b0, i_raddr[ADDR_WIDTH-1:1]};
    assign w_unused = ^{i_waddr[0], i_raddr[0]};

    // Program-load write; out-of-range halfwords are dropped.
    always_ff @(posedge i_clk) begin
        if (i_we && (w_widx < DEPTH)) begin
            r_mem[IDX_W'(w_widx)] <= i_wdata;
        end
    end

    // Assemble ILEN bits from consecutive halfwords, no wrap-around.
    always_comb begin
        o_rdata = '0;
        for (int k = 0; k < NHW; k++) begin
            if ((w_ridx + ADDR_WIDTH'(k)) < DEPTH) begin
                o_rdata[k*HWORD_WIDTH +: HWORD_WIDTH] =
                    r_mem[IDX_W'(w_ridx + ADDR_WIDTH'(k))];
            end
        end
    end

endmodule

// File: rtl/instruction_memory.sv
// Instruction-fetch responder: accepts a request, waits LATENCY cycles,
// then returns the instruction with a single-cycle ack.
module instruction_memory
    import sp_pkg::*;
#(
    parameter int MEM_DEPTH = 1024,
    parameter int LATENCY   = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   imem_req_i,
    input  logic [ADDR_WIDTH-1:0]  imem_addr_i,
    output logic [ILEN-1:0]        imem_rdata_o,
    output logic                   imem_ack_o,
    input  logic                   prog_we_i,
    input  logic [ADDR_WIDTH-1:0]  prog_addr_i,
    input  logic [HWORD_WIDTH-1:0] prog_wdata_i
);

    if ((LATENCY < 0) || (LATENCY > 15)) begin : g_bad_latency
        $error("instruction_memory: LATENCY must be within 0..15");
    end
    if ((ILEN % HWORD_WIDTH) != 0) begin : g_bad_ilen
        $error("instruction_memory: ILEN must be a multiple of 16");
    end

    localparam logic [3:0] CNT_INIT =
        (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
    localparam imem_state_e ACC_STATE =
        (LATENCY == 0) ? IMEM_RESP : IMEM_WAIT;

    imem_state_e           r_state;
    imem_state_e           w_next;
    logic [3:0]            r_cnt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ILEN-1:0]       r_rdata;
    logic                  r_ack;
    logic                  w_ready;
    logic                  w_accept;
    logic [ADDR_WIDTH-1:0] w_raddr;
    logic [ILEN-1:0]       w_rdata;

    imem_storage #(
        .MEM_DEPTH (MEM_DEPTH)
    ) u_storage (
        .i_clk   (clk_i),
        .i_we    (prog_we_i),
        .i_waddr (prog_addr_i),
        .i_wdata (prog_wdata_i),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    // State, wait counter, latched address and registered response.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IMEM_IDLE;
            r_cnt   <= 4'd0;
            r_addr  <= '0;
            r_ack   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_state <= w_next;
            r_ack   <= (w_next == IMEM_RESP);
            if (w_accept) begin
                r_addr <= imem_addr_i;
                r_cnt  <= CNT_INIT;
            end else if ((r_state == IMEM_WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_next == IMEM_RESP) begin
                r_rdata <= w_rdata;
            end
        end
    end

    // Next state: requests only count in IDLE or RESP.
    always_comb begin
        w_next = IMEM_IDLE;
        unique case (r_state)
            IMEM_IDLE: w_next = w_accept ? ACC_STATE : IMEM_IDLE;
            IMEM_WAIT: w_next = (r_cnt == 4'd0) ? IMEM_RESP : IMEM_WAIT;
            IMEM_RESP: w_next = w_accept ? ACC_STATE : IMEM_IDLE;
            default:   w_next = IMEM_IDLE;
        endcase
    end

    // Acceptance; a zero-latency read must use the incoming address.
    always_comb begin
        w_ready  = (r_state == IMEM_IDLE) || (r_state == IMEM_RESP);
        w_accept = w_ready && imem_req_i;
        w_raddr  = w_accept ? imem_addr_i : r_addr;
    end

    assign imem_ack_o   = r_ack;
    assign imem_rdata_o = r_rdata;

endmodule

// File: tb/tb_instruction_memory.sv
// Scoreboard bench for instruction_memory at LATENCY 0, 1 and 3.
// Expected (data, ack cycle) pairs are queued at issue and popped on ack.
module tb_instruction_memory;
    import sp_pkg::*;

    typedef struct {
        logic [31:0] d;
        int          c;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [31:0] wa;
    logic [15:0] wd;

    logic        req0, req1, req3;
    logic [31:0] addr0, addr1, addr3;
    logic [31:0] rdata0, rdata1, rdata3;
    logic        ack0, ack1, ack3;

    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   n_ack3 = 0;
    exp_t q0[$], q1[$], q3[$];
    exp_t e0, e1, e3;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    instruction_memory #(.MEM_DEPTH(1024), .LATENCY(0)) u0 (
        .clk_i(clk), .rst_i(rst),
        .imem_req_i(req0), .imem_addr_i(addr0),
        .imem_rdata_o(rdata0), .imem_ack_o(ack0),
        .prog_we_i(we), .prog_addr_i(wa), .prog_wdata_i(wd)
    );

    instruction_memory #(.MEM_DEPTH(1024), .LATENCY(1)) u1 (
        .clk_i(clk), .rst_i(rst),
        .imem_req_i(req1), .imem_addr_i(addr1),
        .imem_rdata_o(rdata1), .imem_ack_o(ack1),
        .prog_we_i(we), .prog_addr_i(wa), .prog_wdata_i(wd)
    );

    instruction_memory #(.MEM_DEPTH(1024), .LATENCY(3)) u3 (
        .clk_i(clk), .rst_i(rst),
        .imem_req_i(req3), .imem_addr_i(addr3),
        .imem_rdata_o(rdata3), .imem_ack_o(ack3),
        .prog_we_i(we), .prog_addr_i(wa), .prog_wdata_i(wd)
    );

    function automatic exp_t mk(logic [31:0] d, int c);
        exp_t e;
        e.d = d;
        e.c = c;
        return e;
    endfunction

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", nm, act, req);
        end
    endfunction

    function automatic void spurious(string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: ack at cycle %0d with nothing expected", nm, cyc);
    endfunction

    // Monitors: pop and compare on every ack.
    always @(negedge clk) begin
        if (ack0 === 1'b1) begin
            if (q0.size() == 0) spurious("u0 ack");
            else begin
                e0 = q0.pop_front();
                chk("u0 rdata", rdata0, e0.d);
                chk("u0 ack cycle", cyc, e0.c);
            end
        end
    end

    always @(negedge clk) begin
        if (ack1 === 1'b1) begin
            if (q1.size() == 0) spurious("u1 ack");
            else begin
                e1 = q1.pop_front();
                chk("u1 rdata", rdata1, e1.d);
                chk("u1 ack cycle", cyc, e1.c);
            end
        end
    end

    always @(negedge clk) begin
        if (ack3 === 1'b1) begin
            n_ack3++;
            if (q3.size() == 0) spurious("u3 ack");
            else begin
                e3 = q3.pop_front();
                chk("u3 rdata", rdata3, e3.d);
                chk("u3 ack cycle", cyc, e3.c);
            end
        end
    end

    task automatic tick(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic prog(logic [31:0] a, logic [15:0] d);
        we = 1'b1;
        wa = a;
        wd = d;
        tick(1);
        we = 1'b0;
    endtask

    task automatic rd1(logic [31:0] a, logic [31:0] d);
        req1  = 1'b1;
        addr1 = a;
        q1.push_back(mk(d, cyc + 2));
        tick(1);
        req1 = 1'b0;
        tick(3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int c;
        int n;
        rst = 1'b1;
        we  = 1'b0;
        wa  = '0;
        wd  = '0;
        {req0, req1, req3}    = 3'b000;
        {addr0, addr1, addr3} = '0;
        tick(1);

        // Load while held in reset: writes must still land.
        prog(32'h000, 16'h1111);
        prog(32'h002, 16'h2222);
        prog(32'h004, 16'h3333);
        prog(32'h006, 16'h4444);
        prog(32'h010, 16'h1234);
        prog(32'h012, 16'hABCD);
        prog(32'h7FE, 16'h5A5A);

        // Request held during reset is never answered.
        req1  = 1'b1;
        addr1 = 32'h10;
        repeat (3) begin
            tick(1);
            chk("reset ack", {31'b0, ack1}, 32'h0);
            chk("reset rdata", rdata1, 32'h0);
        end
        rst = 1'b0;
        q1.push_back(mk(32'hABCD1234, cyc + 2));
        tick(1);
        req1 = 1'b0;
        tick(4);

        // Zero latency, back-to-back.
        req0  = 1'b1;
        addr0 = 32'h0;
        q0.push_back(mk(32'h22221111, cyc + 1));
        tick(1);
        addr0 = 32'h2;
        q0.push_back(mk(32'h33332222, cyc + 1));
        tick(1);
        addr0 = 32'h4;
        q0.push_back(mk(32'h44443333, cyc + 1));
        tick(1);
        req0 = 1'b0;
        tick(3);

        // LATENCY 3: address changes in WAIT are ignored.
        req3  = 1'b1;
        addr3 = 32'h10;
        t = cyc + 4;
        q3.push_back(mk(32'hABCD1234, t));
        q3.push_back(mk(32'h22221111, t + 4));
        tick(1);
        addr3 = 32'h2;
        while (cyc < t) tick(1);
        addr3 = 32'h0;
        while (cyc < t + 4) tick(1);
        req3 = 1'b0;
        tick(3);

        // End of array.
        rd1(32'h7FE, 32'h00005A5A);
        rd1(32'h800, 32'h00000000);
        prog(32'h800, 16'hDEAD);
        rd1(32'h000, 32'h22221111);
        rd1(32'h7FE, 32'h00005A5A);

        // Reset during WAIT aborts the request.
        req3  = 1'b1;
        addr3 = 32'h10;
        tick(1);
        req3 = 1'b0;
        n = n_ack3;
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(6);
        chk("u3 abort ack count", n_ack3, n);

        // Write on the capture edge is not seen by that read.
        req3  = 1'b1;
        addr3 = 32'h0;
        c = cyc;
        q3.push_back(mk(32'h22221111, c + 4));
        tick(1);
        req3 = 1'b0;
        while (cyc < c + 3) tick(1);
        prog(32'h000, 16'hBEEF);
        tick(2);
        req3  = 1'b1;
        addr3 = 32'h0;
        q3.push_back(mk(32'h2222BEEF, cyc + 4));
        tick(1);
        req3 = 1'b0;
        tick(8);

        chk("u0 pending", q0.size(), 0);
        chk("u1 pending", q1.size(), 0);
        chk("u3 pending", q3.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
